// File: rtl/multicycle_issue_ctrl.sv
// Issue controller for the multiply/divide unit: launches one op at a time,
// short-circuits divide-by-zero, and hands the result to the next stage.
package multicycle_issue_pkg;
    typedef enum logic [3:0] {
        OP_MUL, OP_MULW, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } op_t;
endpackage

module multicycle_issue_ctrl
    import multicycle_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  op_t         op,
    input  logic        is_32instr,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        flush,
    input  logic        downstream_stall,
    output logic        stall_out,
    output logic        res_valid,
    output logic [63:0] res,
    output logic        unit_start,
    output op_t         unit_op,
    output logic [63:0] unit_a,
    output logic [63:0] unit_b,
    input  logic        unit_done,
    input  logic [63:0] unit_c
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

    state_t      state_q;
    op_t         op_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    logic [63:0] res_q;
    logic        w_q;
    logic        start_q;
    logic        res_valid_q;

    logic        is_div;
    logic        is_rem;
    logic        div_zero;
    logic [63:0] zero_res;
    logic [63:0] unit_res;

    assign is_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                                 OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    assign is_rem   = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
    assign div_zero = is_div && (is_32instr ? (b[31:0] == 32'd0) : (b == 64'd0));

    // Divide-by-zero: quotient is all ones, remainder is the dividend.
    assign zero_res = is_rem ? (is_32instr ? {{32{a[31]}}, a[31:0]} : a)
                             : {64{1'b1}};
    assign unit_res = w_q ? {{32{unit_c[31]}}, unit_c[31:0]} : unit_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_MUL;
            a_q         <= 64'd0;
            b_q         <= 64'd0;
            res_q       <= 64'd0;
            w_q         <= 1'b0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && !flush) begin
                        if (div_zero) begin
                            res_q       <= zero_res;
                            res_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            op_q    <= op;
                            a_q     <= a;
                            b_q     <= b;
                            w_q     <= is_32instr;
                            start_q <= 1'b1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // A flush coinciding with completion drops the result outright.
                    if (flush) begin
                        state_q <= unit_done ? IDLE : ABORT;
                    end else if (unit_done) begin
                        res_q       <= unit_res;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                ABORT: begin
                    if (unit_done) begin
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    if (flush || !downstream_stall) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_out  = !reset && ((state_q == IDLE && req_valid && !flush)
                                   || state_q == BUSY || state_q == ABORT);
    assign res_valid  = res_valid_q;
    assign res        = res_q;
    assign unit_start = start_q;
    assign unit_op    = op_q;
    assign unit_a     = a_q;
    assign unit_b     = b_q;

endmodule
